// File: rtl/dbgreg_mailbox.sv
// JTAG debug-register mailbox: filtered 33-bit FIFO of DR words drained over a simple CPU bus.
// Optional overflow drop counter at addr 3 is compiled in with `define DBGREG_OVFCNT_EN.
`timescale 1ns/1ps
module dbgreg_mailbox #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dbgreg_in,
    input  logic        dbgreg_sel,
    input  logic        dbgreg_strobe,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [32:0] mem [DEPTH];
    logic [AW:0] wptr, rptr, count;
    logic [32:0] head;
    logic        empty, full;
    logic        ovf, irq_en, filt_en, filt_val;
    logic        req_wen;
    logic [1:0]  req_addr;
    logic [3:0]  req_bits;
    logic        accept, pop, flush, push, drop;
    logic        wr_status, wr_ctrl, wr_ovfcnt;
    logic [31:0] status, ctrl_rd, ovfcnt_rd, rdata;
    logic        unused_bits;

    assign unused_bits = ^data_in[31:4];

    assign count = wptr - rptr;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = mem[rptr[AW-1:0]];

    // Bus actions take effect at the end of the ready cycle, so a pop there can
    // coincide with a strobe and make room for it.
    assign pop       = ready && !req_wen && (req_addr == 2'd0) && !empty;
    assign wr_status = ready && req_wen && (req_addr == 2'd1);
    assign wr_ctrl   = ready && req_wen && (req_addr == 2'd2);
    assign wr_ovfcnt = ready && req_wen && (req_addr == 2'd3);
    assign flush     = wr_ctrl && req_bits[1];

    assign accept = dbgreg_strobe && (!filt_en || (dbgreg_sel == filt_val));
    assign push   = accept && !flush && (!full || pop);
    assign drop   = accept && !flush && full && !pop;

    assign status  = {17'b0, 7'(count), 4'b0, (!empty && head[32]), ovf, full, !empty};
    assign ctrl_rd = {28'b0, filt_val, filt_en, 1'b0, irq_en};

`ifdef DBGREG_OVFCNT_EN
    logic [15:0] ovfcnt;

    always_ff @(posedge clk) begin
        if (rst)
            ovfcnt <= '0;
        else if (wr_ovfcnt)
            ovfcnt <= '0;
        else if (drop && (ovfcnt != 16'hFFFF))
            ovfcnt <= ovfcnt + 16'd1;
    end

    assign ovfcnt_rd = {16'b0, ovfcnt};
`else
    logic unused_ovfcnt;
    assign unused_ovfcnt = wr_ovfcnt;
    assign ovfcnt_rd     = 32'b0;
`endif

    always_comb begin
        rdata = 32'b0;
        case (req_addr)
            2'd0:    rdata = empty ? 32'b0 : head[31:0];
            2'd1:    rdata = status;
            2'd2:    rdata = ctrl_rd;
            default: rdata = ovfcnt_rd;
        endcase
    end

    assign data_out = (ready && !req_wen) ? rdata : 32'b0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= {dbgreg_sel, dbgreg_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ovf      <= 1'b0;
            irq_en   <= 1'b0;
            filt_en  <= 1'b0;
            filt_val <= 1'b0;
            ready    <= 1'b0;
            req_wen  <= 1'b0;
            req_addr <= 2'd0;
            req_bits <= 4'd0;
            irq      <= 1'b0;
        end else begin
            // A request is only captured while idle; ready is never high twice in a row.
            if (!ready && (wen || ren)) begin
                ready    <= 1'b1;
                req_wen  <= wen;
                req_addr <= addr;
                req_bits <= data_in[3:0];
            end else begin
                ready <= 1'b0;
            end

            if (flush)
                rptr <= wptr;
            else if (pop)
                rptr <= rptr + 1'b1;

            if (push)
                wptr <= wptr + 1'b1;

            if (wr_ctrl) begin
                irq_en   <= req_bits[0];
                filt_en  <= req_bits[2];
                filt_val <= req_bits[3];
            end

            if (drop)
                ovf <= 1'b1;
            else if (wr_status && req_bits[2])
                ovf <= 1'b0;

            irq <= irq_en && (!empty || ovf);
        end
    end
endmodule

// File: tb/tb_dbgreg_mailbox.sv
// Directed self-checking bench for dbgreg_mailbox (DEPTH=8); OVFCNT expectations follow DBGREG_OVFCNT_EN.
`timescale 1ns/1ps
module tb_dbgreg_mailbox;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dbgreg_in = '0;
    logic        dbgreg_sel = 1'b0;
    logic        dbgreg_strobe = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] data_out;
    logic        ready;
    logic        irq;

    int checks = 0;
    int passed = 0;

    dbgreg_mailbox #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .dbgreg_in(dbgreg_in), .dbgreg_sel(dbgreg_sel),
        .dbgreg_strobe(dbgreg_strobe), .addr(addr), .data_in(data_in),
        .wen(wen), .ren(ren), .data_out(data_out), .ready(ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic strobe(input logic [31:0] d, input logic s);
        dbgreg_in = d; dbgreg_sel = s; dbgreg_strobe = 1'b1;
        @(posedge clk); #1;
        dbgreg_strobe = 1'b0;
    endtask

    // One bus transaction; optionally pulses a strobe during the ready cycle.
    // ack is 1 only if ready was high in the ack cycle and low right after.
    task automatic bus_op(input logic is_wr, input logic [1:0] a, input logic [31:0] wd,
                          input logic stb, input logic [31:0] sd, input logic ss,
                          output logic [31:0] rd, output logic ack);
        wen = is_wr; ren = !is_wr; addr = a; data_in = wd;
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0;
        dbgreg_in = sd; dbgreg_sel = ss; dbgreg_strobe = stb;
        ack = ready; rd = data_out;
        @(posedge clk); #1;
        dbgreg_strobe = 1'b0;
        if (ready !== 1'b0) ack = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd);
        logic ack;
        bus_op(1'b0, a, 32'h0, 1'b0, 32'h0, 1'b0, rd, ack);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        logic ack;
        bus_op(1'b1, a, wd, 1'b0, 32'h0, 1'b0, rd, ack);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1; ren = 1'b1; addr = 2'd0;
        dbgreg_strobe = 1'b1; dbgreg_in = 32'h1234; dbgreg_sel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; ren = 1'b0; dbgreg_strobe = 1'b0;
        checks++;
        if ({ready, irq, data_out} !== 34'b0)
            $display("[TB] FAIL reset_outputs: got ready=%b irq=%b data_out=%h, need 0/0/0", ready, irq, data_out);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0) $display("[TB] FAIL reset_no_ready: got %b, need 0", ready);
        else passed++;
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h0) $display("[TB] FAIL reset_status: got %h, need 00000000", rd);
        else passed++;
        rd_reg(2'd2, rd);
        checks++;
        if (rd !== 32'h0) $display("[TB] FAIL reset_ctrl: got %h, need 00000000", rd);
        else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        strobe(32'hDEADBEEF, 1'b1);
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h00000109) $display("[TB] FAIL basic_status: got %h, need 00000109", rd);
        else passed++;
        rd_reg(2'd0, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) $display("[TB] FAIL basic_data: got %h, need DEADBEEF", rd);
        else passed++;
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h0) $display("[TB] FAIL basic_status_empty: got %h, need 00000000", rd);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        for (int i = 1; i <= 9; i++) strobe(32'(i), 1'b0);
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h00000807) $display("[TB] FAIL ovf_status: got %h, need 00000807", rd);
        else passed++;
        for (int i = 1; i <= 8; i++) begin
            rd_reg(2'd0, rd);
            checks++;
            if (rd !== 32'(i)) $display("[TB] FAIL ovf_order[%0d]: got %h, need %h", i, rd, 32'(i));
            else passed++;
        end
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h00000004) $display("[TB] FAIL ovf_sticky: got %h, need 00000004", rd);
        else passed++;
        wr_reg(2'd1, 32'h4);
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h0) $display("[TB] FAIL ovf_clear: got %h, need 00000000", rd);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, want;
        logic ack;
        for (int i = 1; i <= 8; i++) strobe(32'(i), 1'b0);
        bus_op(1'b0, 2'd0, 32'h0, 1'b1, 32'hA5, 1'b0, rd, ack);
        checks++;
        if (rd !== 32'h1 || ack !== 1'b1) $display("[TB] FAIL b2b_pop: got %h ack=%b, need 00000001 ack=1", rd, ack);
        else passed++;
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h00000803) $display("[TB] FAIL b2b_status: got %h, need 00000803", rd);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            want = (i < 7) ? 32'(i + 2) : 32'hA5;
            rd_reg(2'd0, rd);
            checks++;
            if (rd !== want) $display("[TB] FAIL b2b_drain[%0d]: got %h, need %h", i, rd, want);
            else passed++;
        end
    endtask

    task automatic test_filter();
        logic [31:0] rd;
        logic ack;
        wr_reg(2'd2, 32'hC);
        strobe(32'h11, 1'b0);
        strobe(32'h22, 1'b1);
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h00000109) $display("[TB] FAIL filt_status: got %h, need 00000109", rd);
        else passed++;
        rd_reg(2'd0, rd);
        checks++;
        if (rd !== 32'h22) $display("[TB] FAIL filt_data: got %h, need 00000022", rd);
        else passed++;
        bus_op(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, rd, ack);
        checks++;
        if (rd !== 32'h0 || ack !== 1'b1) $display("[TB] FAIL filt_empty_read: got %h ack=%b, need 00000000 ack=1", rd, ack);
        else passed++;
        rd_reg(2'd2, rd);
        checks++;
        if (rd !== 32'hC) $display("[TB] FAIL filt_ctrl: got %h, need 0000000C", rd);
        else passed++;
        wr_reg(2'd2, 32'h0);
    endtask

    task automatic test_irq_flush();
        logic [31:0] rd;
        logic ack;
        wr_reg(2'd2, 32'h1);
        strobe(32'h33, 1'b0);
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL irq_early: got %b, need 0", irq);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) $display("[TB] FAIL irq_rise: got %b, need 1", irq);
        else passed++;
        bus_op(1'b1, 2'd2, 32'h3, 1'b1, 32'h44, 1'b0, rd, ack);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL irq_fall: got %b, need 0", irq);
        else passed++;
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h0) $display("[TB] FAIL flush_status: got %h, need 00000000", rd);
        else passed++;
        rd_reg(2'd2, rd);
        checks++;
        if (rd !== 32'h1) $display("[TB] FAIL flush_ctrl: got %h, need 00000001", rd);
        else passed++;
        wr_reg(2'd2, 32'h0);
    endtask

    task automatic test_ovfcnt();
        logic [31:0] rd, want;
`ifdef DBGREG_OVFCNT_EN
        want = 32'd3;
`else
        want = 32'd0;
`endif
        wr_reg(2'd3, 32'h0);
        for (int i = 0; i < 11; i++) strobe(32'(100 + i), 1'b0);
        rd_reg(2'd3, rd);
        checks++;
        if (rd !== want) $display("[TB] FAIL ovfcnt_value: got %h, need %h", rd, want);
        else passed++;
        wr_reg(2'd3, 32'h0);
        rd_reg(2'd3, rd);
        checks++;
        if (rd !== 32'h0) $display("[TB] FAIL ovfcnt_clear: got %h, need 00000000", rd);
        else passed++;
        wr_reg(2'd2, 32'h2);
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h4) $display("[TB] FAIL ovfcnt_flush_status: got %h, need 00000004", rd);
        else passed++;
        wr_reg(2'd1, 32'h4);
    endtask

    task automatic test_data_write();
        logic [31:0] rd;
        logic ack;
        strobe(32'h55, 1'b1);
        bus_op(1'b1, 2'd0, 32'hFFFF, 1'b0, 32'h0, 1'b0, rd, ack);
        checks++;
        if (ack !== 1'b1 || rd !== 32'h0) $display("[TB] FAIL dwr_ack: got ack=%b data_out=%h, need 1/00000000", ack, rd);
        else passed++;
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h00000109) $display("[TB] FAIL dwr_status: got %h, need 00000109", rd);
        else passed++;
        rd_reg(2'd0, rd);
        checks++;
        if (rd !== 32'h55) $display("[TB] FAIL dwr_data: got %h, need 00000055", rd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_filter();
        test_irq_flush();
        test_ovfcnt();
        test_data_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dbgreg_mailbox.md
DBGREG_MAILBOX -- requirements
Module: dbgreg_mailbox

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in words (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  system clock (48 MHz domain); all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port dbgreg_in  input  32  JTAG DR word.
REQ-005 SHALL have port dbgreg_sel  input  1  word source tag (0 = IR 0x32, 1 = IR 0x38).
REQ-006 SHALL have port dbgreg_strobe  input  1  one-cycle pulse; dbgreg_in/dbgreg_sel valid this cycle.
REQ-007 SHALL have port addr  input  2  word register select (0 DATA, 1 STATUS, 2 CTRL, 3 OVFCNT).
REQ-008 SHALL have port data_in  input  32  bus write data.
REQ-009 SHALL have port wen  input  1  bus write request.
REQ-010 SHALL have port ren  input  1  bus read request.
REQ-011 SHALL have port data_out  output  32  bus read data, valid while ready=1.
REQ-012 SHALL have port ready  output  1  one-cycle bus acknowledge.
REQ-013 SHALL have port irq  output  1  level interrupt to CPU.

Function
REQ-014 SHALL store {sel,data} (33 bits) per entry in a circular FIFO; read and write pointers SHALL be log2(DEPTH)+1 bits; count = wptr-rptr.
REQ-015 On dbgreg_strobe with filter accept and count<DEPTH, SHALL push; the new count SHALL be visible in STATUS on the next cycle.
REQ-016 Filter accept = !ctrl.filt_en || (dbgreg_sel == ctrl.filt_val); a rejected strobe SHALL be discarded silently (no overflow, no count).
REQ-017 On an accepted strobe while full (and no pop in the same cycle), SHALL drop the word, set sticky ovf, and leave FIFO contents unchanged.
REQ-018 Bus: on wen or ren, ready SHALL assert exactly one cycle later for one cycle; new requests while ready=1 SHALL be ignored; data_out SHALL be 0 whenever ready=0.
REQ-019 DATA read: if not empty, data_out = head data and the head SHALL be popped in the ready cycle; if empty, data_out = 0 and no pop.
REQ-020 STATUS read: [0] not_empty, [1] full, [2] ovf, [3] head sel tag (0 if empty), [14:8] count; other bits 0.
REQ-021 STATUS write: data_in[2]=1 SHALL clear ovf; other bits ignored.
REQ-022 CTRL read/write: [0] irq_en, [2] filt_en, [3] filt_val; bit [1] flush SHALL be write-only, self-clearing, reading 0.
REQ-023 Flush SHALL set rptr=wptr in the ready cycle; a strobe in that cycle SHALL be dropped without setting ovf.
REQ-024 Push and pop in the same cycle while full SHALL both take effect (no ovf); push and pop while empty: the read returns 0, the push is accepted.
REQ-025 Writes to DATA SHALL be acknowledged and have no effect.
REQ-026 irq SHALL be registered: irq <= irq_en && (not_empty || ovf), asserting one cycle after the condition arises.
REQ-027 Pointer wrap SHALL be modulo 2*DEPTH with no lost or duplicated entries across wrap.

Reset
REQ-028 On rst: pointers 0, ovf 0, CTRL 0, OVFCNT 0, ready 0, data_out 0, irq 0; FIFO storage contents need not be cleared.
REQ-029 rst SHALL override any coincident strobe or bus request; an in-flight read SHALL not produce ready after reset.

Configuration
REQ-030 Macro DBGREG_OVFCNT_EN: when defined, OVFCNT (addr 3) SHALL be a 16-bit saturating (at 0xFFFF) count of words dropped per REQ-017, readable in [15:0], and any write SHALL clear it.
REQ-031 When DBGREG_OVFCNT_EN is undefined, addr 3 SHALL read 0, writes SHALL be acknowledged with no effect, and no counter logic SHALL be synthesized.

Verification
REQ-032 Reset, strobe 0xDEADBEEF sel=1, read STATUS -> 0x00000109; read DATA -> 0xDEADBEEF; STATUS -> 0x00000000.
REQ-033 DEPTH=8: 9 strobes 1..9 -> STATUS 0x00000807 (full, ovf); 8 DATA reads -> 1..8 in order; write STATUS 0x4 -> ovf cleared.
REQ-034 Full FIFO, DATA read pop coincident with strobe 0xA5 -> no ovf, count stays 8, last read returns 0xA5.
REQ-035 CTRL=0xC (filter sel=1), strobes sel=0 0x11 and sel=1 0x22 -> count 1, DATA read = 0x22; empty DATA read -> 0, ready still pulses.
REQ-036 CTRL=0x1, strobe -> irq high one cycle after the push; write CTRL=0x3 -> FIFO empty, irq low next cycle, CTRL reads 0x1.
REQ-037 With DBGREG_OVFCNT_EN, 3 strobes into a full FIFO -> OVFCNT reads 3; write addr 3 -> reads 0; without macro -> always 0.
